// File: rtl/i2c_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_pkg
// Purpose  : Shared types and sizes for the I2C target register block.
//            Holds the FSM state enum and the register-file geometry.
// Revision : 1.0  initial release
// ============================================================================
package i2c_target_pkg;

  localparam int NREGS  = 16;
  localparam int PTR_W  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_sync
// Purpose  : Synchronises raw SCL/SDA pins and detects bus events.
//            Two sync flops per pin plus one history flop for edge detection.
// Ports    : clk, reset_n        clock / async active-low reset
//            scl_in, sda_in      raw pin levels
//            scl, sda            synchronised levels
//            scl_rise, scl_fall  one-cycle SCL edge pulses
//            start_det, stop_det one-cycle START / STOP pulses
// Revision : 1.0  initial release
// ============================================================================
module i2c_bus_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0] r_vld;
  logic       w_arm;

  // Pipeline resets to the idle-bus level (both lines high).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
      r_vld    <= 3'b000;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
      r_vld    <= {r_vld[1:0], 1'b1};
    end
  end

  // Events stay masked until the history stage holds a real pin sample,
  // otherwise a low SDA at reset release would look like a START.
  assign w_arm = r_vld[2];

  assign scl       = r_scl_s2;
  assign sda       = r_sda_s2;
  assign scl_rise  = w_arm &  r_scl_s2 & ~r_scl_d;
  assign scl_fall  = w_arm & ~r_scl_s2 &  r_scl_d;
  assign start_det = w_arm & r_scl_s2 & r_scl_d &  r_sda_d & ~r_sda_s2;
  assign stop_det  = w_arm & r_scl_s2 & r_scl_d & ~r_sda_d &  r_sda_s2;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regs
// Purpose  : I2C target with a 16 x 8 register file shared with an
//            Avalon-MM host port. Never stretches SCL.
// Ports    : clk, reset_n                 clock / async active-low reset
//            address, chipselect, write_n,
//            writedata, readdata          Avalon-MM slave (registered read)
//            scl_in, sda_in               raw I2C pin levels
//            sda_oe                       1 pulls SDA low
//            busy                         addressed transaction in progress
//            i2c_wr                       pulse per I2C register write
// Revision : 1.0  initial release
// ============================================================================
module i2c_target_regs
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PTR_W-1:0]  address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [BYTE_W-1:0] writedata,
  output logic [BYTE_W-1:0] readdata,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              busy,
  output logic              i2c_wr
);

  logic w_unused_scl, w_sda, w_rise, w_fall, w_start, w_stop;

  // SCL level is not needed here: its edges carry all the timing.
  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl       (w_unused_scl),
    .sda       (w_sda),
    .scl_rise  (w_rise),
    .scl_fall  (w_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  state_t              r_state, w_state_nx;
  logic [3:0]          r_cnt, w_cnt_nx;
  logic [BYTE_W-1:0]   r_shift, w_shift_nx;
  logic [PTR_W-1:0]    r_ptr, w_ptr_nx;
  logic                r_sda_oe, w_oe_nx;
  logic                r_busy, w_busy_nx;
  logic                r_rw, w_rw_nx;
  logic                r_i2c_wr;
  logic                w_reg_we;
  logic [BYTE_W-1:0]   w_byte, w_rd_byte;
  logic [BYTE_W-1:0]   r_regs [NREGS];
  logic [BYTE_W-1:0]   r_readdata;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_shift_nx = r_shift;
    w_ptr_nx   = r_ptr;
    w_oe_nx    = r_sda_oe;
    w_busy_nx  = r_busy;
    w_rw_nx    = r_rw;
    w_reg_we   = 1'b0;
    w_byte     = {r_shift[BYTE_W-2:0], w_sda};
    w_rd_byte  = r_regs[r_ptr];

    if (w_stop) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = 4'd0;
      w_oe_nx    = 1'b0;
      w_busy_nx  = 1'b0;
    end else if (w_start) begin
      w_state_nx = S_ADDR;
      w_cnt_nx   = 4'd0;
      w_oe_nx    = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_rise && r_cnt < 4'd8) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = r_cnt + 4'd1;
            // Byte completes on this rise: commit pointer / register now.
            if (r_cnt == 4'd7) begin
              if (r_state == S_PTR) begin
                w_ptr_nx = w_byte[PTR_W-1:0];
              end else if (r_state == S_WDATA) begin
                w_reg_we = 1'b1;
                w_ptr_nx = r_ptr + 4'd1;
              end
            end
          end else if (w_fall && r_cnt == 4'd8) begin
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == DEV_ADDR) begin
                w_state_nx = S_ADDR_ACK;
                w_oe_nx    = 1'b1;
                w_busy_nx  = 1'b1;
                w_rw_nx    = r_shift[0];
              end else begin
                w_state_nx = S_IDLE;
                w_busy_nx  = 1'b0;
              end
            end else begin
              w_state_nx = (r_state == S_PTR) ? S_PTR_ACK : S_WDATA_ACK;
              w_oe_nx    = 1'b1;
            end
          end
        end

        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (w_fall) begin
            w_cnt_nx = 4'd0;
            w_oe_nx  = 1'b0;
            if (r_state == S_ADDR_ACK && r_rw) begin
              // Read byte is captured here, so later host writes can't alter it.
              w_state_nx = S_RDATA;
              w_shift_nx = w_rd_byte;
              w_oe_nx    = ~w_rd_byte[BYTE_W-1];
              w_ptr_nx   = r_ptr + 4'd1;
            end else if (r_state == S_ADDR_ACK) begin
              w_state_nx = S_PTR;
            end else begin
              w_state_nx = S_WDATA;
            end
          end
        end

        S_RDATA: begin
          if (w_rise && r_cnt < 4'd8) begin
            w_cnt_nx = r_cnt + 4'd1;
          end else if (w_fall && r_cnt == 4'd8) begin
            w_state_nx = S_RDATA_ACK;
            w_cnt_nx   = 4'd0;
            w_oe_nx    = 1'b0;
          end else if (w_fall && r_cnt != 4'd0) begin
            w_shift_nx = {r_shift[BYTE_W-2:0], 1'b0};
            w_oe_nx    = ~r_shift[BYTE_W-2];
          end
        end

        S_RDATA_ACK: begin
          // A NACK leaves the state on the rise; any fall seen here follows an ACK.
          if (w_rise && w_sda) begin
            w_state_nx = S_IDLE;
          end else if (w_fall) begin
            w_state_nx = S_RDATA;
            w_shift_nx = w_rd_byte;
            w_oe_nx    = ~w_rd_byte[BYTE_W-1];
            w_ptr_nx   = r_ptr + 4'd1;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_sda_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_rw     <= 1'b0;
      r_i2c_wr <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_shift  <= w_shift_nx;
      r_ptr    <= w_ptr_nx;
      r_sda_oe <= w_oe_nx;
      r_busy   <= w_busy_nx;
      r_rw     <= w_rw_nx;
      r_i2c_wr <= w_reg_we;
    end
  end

  // The I2C write is issued last so it overrides a same-cycle host write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_readdata <= '0;
    end else begin
      if (chipselect && !write_n) r_regs[address] <= writedata;
      if (w_reg_we)               r_regs[r_ptr]   <= w_byte;
      r_readdata <= r_regs[address];
    end
  end

  assign readdata = r_readdata;
  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign i2c_wr   = r_i2c_wr;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_regs
// Purpose  : Self-checking bench for i2c_target_regs. A bus-level I2C
//            controller drives SCL/SDA; a register-array model tracks what
//            every register must hold and readdata is compared against it.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_target_regs;

  localparam int HALF = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] address = 4'd0;
  logic       chipselect = 1'b0;
  logic       write_n = 1'b1;
  logic [7:0] writedata = 8'd0;
  logic [7:0] readdata;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, i2c_wr;

  assign sda_line = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .scl_in     (scl_drv),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .i2c_wr     (i2c_wr)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         quiet_until = 0;
  int         wr_seen = 0;
  bit         oe_seen = 1'b0;
  bit         done = 1'b0;
  logic [7:0] mdl_regs [16];
  logic [3:0] mdl_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic av_write(input logic [3:0] a, input logic [7:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    mdl_regs[a] = d;
    quiet_until = cyc + 4;
  endtask

  task automatic av_read_chk(input logic [3:0] a, input logic [7:0] exp, input string name);
    address = a;
    quiet_until = cyc + 4;
    @(posedge clk); #1;
    chk(name, readdata, exp);
  endtask

  // One SCL clock: SDA set while low, sampled mid-high. coll makes a host
  // write to reg 2 land on the clk edge that the DUT sees this rise.
  task automatic slot(input logic b, input bit coll, output logic line, output logic oe);
    wait_clk(4); sda_drv = b; wait_clk(HALF - 4);
    scl_drv = 1'b1;
    if (coll) begin
      repeat (2) @(posedge clk); #1;
      address = 4'd2; writedata = 8'h55; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      wait_clk(HALF/2 - 3);
    end else begin
      wait_clk(HALF/2);
    end
    line = sda_line; oe = sda_oe;
    wait_clk(HALF/2);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(4); sda_drv = 1'b1; wait_clk(HALF - 4);
    scl_drv = 1'b1; wait_clk(HALF/2);
    sda_drv = 1'b0; wait_clk(HALF/2);
    scl_drv = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(4); sda_drv = 1'b0; wait_clk(HALF - 4);
    scl_drv = 1'b1; wait_clk(HALF/2);
    sda_drv = 1'b1; wait_clk(HALF);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit exp_ack, input int wr_idx,
                            input bit coll, input string name);
    logic line, oe;
    bit   any_oe;
    logic [3:0] idx;
    any_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && wr_idx >= 0) begin
        idx = wr_idx[3:0];
        mdl_regs[idx] = b;
        quiet_until = cyc + 2*HALF + 8;
      end
      slot(b[i], coll && (i == 0), line, oe);
      if (oe) any_oe = 1'b1;
    end
    chk({name, " data oe"}, any_oe, 0);
    slot(1'b1, 1'b0, line, oe);
    chk({name, " ack"}, line, exp_ack ? 0 : 1);
  endtask

  task automatic read_byte(input bit ack, input logic [7:0] exp, input string name);
    logic [7:0] got;
    logic line, oe;
    for (int i = 7; i >= 0; i--) begin
      slot(1'b1, 1'b0, line, oe);
      got[i] = line;
    end
    chk({name, " byte"}, got, exp);
    slot(ack ? 1'b0 : 1'b1, 1'b0, line, oe);
    chk({name, " ack slot oe"}, oe, 0);
  endtask

  task automatic reg_write(input logic [7:0] p, input int n, input logic [7:0] d0,
                           input logic [7:0] d1, input bit coll);
    i2c_start();
    write_byte({7'h1A, 1'b0}, 1'b1, -1, 1'b0, "addr w");
    chk("busy after addr", busy, 1);
    write_byte(p, 1'b1, -1, 1'b0, "ptr");
    mdl_ptr = p[3:0];
    for (int k = 0; k < n; k++) begin
      write_byte((k == 0) ? d0 : d1, 1'b1, int'(mdl_ptr), coll, "wdata");
      mdl_ptr = mdl_ptr + 4'd1;
    end
    i2c_stop();
    chk("busy after stop", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl_regs[i] = 8'h00;
    mdl_ptr = 4'd0;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          cyc++;
          if (i2c_wr) wr_seen++;
          if (sda_oe) oe_seen = 1'b1;
          if (reset_n && cyc >= quiet_until)
            chk("readdata vs model", readdata, mdl_regs[address]);
        end
      end
      begin
        // Reset state
        wait_clk(5);
        chk("reset readdata", readdata, 0);
        chk("reset sda_oe", sda_oe, 0);
        chk("reset busy", busy, 0);
        chk("reset i2c_wr", i2c_wr, 0);
        reset_n = 1'b1;
        wait_clk(8);

        // Single register write
        reg_write(8'h03, 1, 8'hA5, 8'h00, 1'b0);
        chk("wr pulses after write", wr_seen, 1);
        av_read_chk(4'd3, 8'hA5, "reg3 after write");

        // Burst write wrapping 15 -> 0
        reg_write(8'h0F, 2, 8'h11, 8'h22, 1'b0);
        chk("wr pulses after burst", wr_seen, 3);
        av_read_chk(4'd15, 8'h11, "reg15 burst");
        av_read_chk(4'd0, 8'h22, "reg0 burst wrap");

        // Read after repeated START
        av_write(4'd5, 8'h3C);
        av_write(4'd6, 8'hC3);
        i2c_start();
        write_byte(8'h34, 1'b1, -1, 1'b0, "rd addr w");
        write_byte(8'h05, 1'b1, -1, 1'b0, "rd ptr");
        mdl_ptr = 4'd5;
        i2c_start();
        write_byte(8'h35, 1'b1, -1, 1'b0, "rd addr r");
        chk("model reg5", mdl_regs[mdl_ptr], 8'h3C);
        read_byte(1'b1, mdl_regs[mdl_ptr], "read0");
        mdl_ptr = mdl_ptr + 4'd1;
        chk("model reg6", mdl_regs[mdl_ptr], 8'hC3);
        read_byte(1'b0, mdl_regs[mdl_ptr], "read1");
        wait_clk(6);
        chk("sda_oe after nack", sda_oe, 0);
        i2c_stop();
        chk("busy after read stop", busy, 0);

        // Address mismatch
        oe_seen = 1'b0;
        i2c_start();
        write_byte(8'h36, 1'b0, -1, 1'b0, "bad addr");
        chk("busy on mismatch", busy, 0);
        write_byte(8'h03, 1'b0, -1, 1'b0, "bad addr ptr");
        i2c_stop();
        chk("sda_oe never driven on mismatch", oe_seen, 0);
        chk("wr pulses after mismatch", wr_seen, 3);
        av_read_chk(4'd3, 8'hA5, "reg3 after mismatch");

        // Same-cycle host and I2C write to reg 2
        reg_write(8'h02, 1, 8'h99, 8'h00, 1'b1);
        av_read_chk(4'd2, 8'h99, "collision reg2");
        chk("wr pulses after collision", wr_seen, 4);

        // STOP in the middle of a data byte
        begin
          logic line, oe;
          i2c_start();
          write_byte(8'h34, 1'b1, -1, 1'b0, "abort addr");
          write_byte(8'h07, 1'b1, -1, 1'b0, "abort ptr");
          slot(1'b1, 1'b0, line, oe);
          slot(1'b0, 1'b0, line, oe);
          slot(1'b1, 1'b0, line, oe);
          i2c_stop();
        end
        chk("busy after abort", busy, 0);
        chk("wr pulses after abort", wr_seen, 4);
        av_read_chk(4'd7, 8'h00, "reg7 after abort");
        reg_write(8'h08, 1, 8'h5A, 8'h00, 1'b0);
        av_read_chk(4'd8, 8'h5A, "reg8 after abort");
        chk("wr pulses after recovery", wr_seen, 5);

        // Reset while the target drives a read bit low
        i2c_start();
        write_byte(8'h34, 1'b1, -1, 1'b0, "rst addr w");
        write_byte(8'h09, 1'b1, -1, 1'b0, "rst ptr");
        i2c_start();
        write_byte(8'h35, 1'b1, -1, 1'b0, "rst addr r");
        wait_clk(8);
        chk("sda_oe driving reg9 bit7", sda_oe, 1);
        reset_n = 1'b0;
        #1;
        chk("sda_oe async reset", sda_oe, 0);
        for (int i = 0; i < 16; i++) mdl_regs[i] = 8'h00;
        wait_clk(3);
        reset_n = 1'b1;
        scl_drv = 1'b1; sda_drv = 1'b1;
        wait_clk(8);
        for (int i = 0; i < 16; i++) av_read_chk(i[3:0], 8'h00, "reg cleared by reset");
        chk("busy after reset", busy, 0);
        reg_write(8'h04, 1, 8'h77, 8'h00, 1'b0);
        av_read_chk(4'd4, 8'h77, "reg4 after reset");
        chk("wr pulses after reset", wr_seen, 6);

        wait_clk(4);
        done = 1'b1;
      end
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
